// File: rtl/pwl_activation_lut.sv
// Piecewise-linear activation segment lookup: classifies an FP16 input against
// programmable ascending boundaries and returns that segment's {coef, bias}.
module pwl_activation_lut #(
  parameter int SEGS   = 16,
  parameter int DATA_W = 16,
  parameter int SEG_W  = $clog2(SEGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SEG_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_coef,
  input  logic [DATA_W-1:0] cfg_bias,
  input  logic [DATA_W-1:0] cfg_bound,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_coef,
  output logic [DATA_W-1:0] out_bias,
  output logic [SEG_W-1:0]  out_seg,
  output logic [DATA_W-1:0] out_x,
  output logic              out_nan,
  output logic              busy
);

  localparam int                NB       = SEGS - 1;
  localparam logic [DATA_W-1:0] NEG_ZERO = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_INF  = DATA_W'(16'h7C00);

  function automatic logic [DATA_W-1:0] fix_neg_zero(input logic [DATA_W-1:0] x);
    return (x == NEG_ZERO) ? '0 : x;
  endfunction

  // Maps FP16 ordering onto unsigned ordering: negatives inverted, positives lifted.
  function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? ~x : (x | NEG_ZERO);
  endfunction

  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (&x[14:10]) && (|x[9:0]);
  endfunction

  logic [DATA_W-1:0] coef_tab  [SEGS];
  logic [DATA_W-1:0] bias_tab  [SEGS];
  logic [DATA_W-1:0] bound_tab [NB];

  logic              stall;
  logic              cfg_ok;
  logic [DATA_W-1:0] x_norm;
  logic [NB-1:0]     cmp_d;

  logic              vld_p1;
  logic [DATA_W-1:0] x_p1;
  logic              nan_p1;
  logic [NB-1:0]     cmp_p1;
  logic [SEG_W-1:0]  seg_sel;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~cfg_we;
  assign busy     = vld_p1 | out_valid;
  assign cfg_ok   = cfg_we & ~busy & (int'(cfg_addr) < SEGS);

  // Stage 0 -> 1: normalise -0 and compare against every boundary in parallel
  always_comb begin
    x_norm = fix_neg_zero(in_x);
    cmp_d  = '0;
    for (int k = 0; k < NB; k++) begin
      cmp_d[k] = order_key(x_norm) < order_key(bound_tab[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      x_p1   <= x_norm;
      nan_p1 <= is_nan(x_norm);
      cmp_p1 <= cmp_d;
    end
  end

  // Stage 1 -> 2: lowest set compare bit wins; NaN and no-hit fall to the top segment
  always_comb begin
    seg_sel = SEG_W'(SEGS - 1);
    if (!nan_p1) begin
      for (int k = NB - 1; k >= 0; k--) begin
        if (cmp_p1[k]) seg_sel = SEG_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_coef <= '0;
      out_bias <= '0;
      out_seg  <= '0;
      out_x    <= '0;
      out_nan  <= 1'b0;
    end else if (!stall && vld_p1) begin
      out_coef <= coef_tab[seg_sel];
      out_bias <= bias_tab[seg_sel];
      out_seg  <= seg_sel;
      out_x    <= x_p1;
      out_nan  <= nan_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      for (int k = 0; k < SEGS; k++) begin
        coef_tab[k] <= '0;
        bias_tab[k] <= '0;
      end
      for (int k = 0; k < NB; k++) begin
        bound_tab[k] <= POS_INF;
      end
    end else begin
      cfg_err <= cfg_we & ~cfg_ok;
      if (!stall) begin
        vld_p1    <= in_valid & in_ready;
        out_valid <= vld_p1;
      end
      // Commits only while the pipe is empty, so in-flight items never see a table change
      if (cfg_ok) begin
        for (int k = 0; k < SEGS; k++) begin
          if (cfg_addr == SEG_W'(k)) begin
            coef_tab[k] <= cfg_coef;
            bias_tab[k] <= cfg_bias;
          end
        end
        for (int k = 0; k < NB; k++) begin
          if (cfg_addr == SEG_W'(k)) bound_tab[k] <= cfg_bound;
        end
      end
    end
  end

endmodule
